// File: rtl/montgomery_reduce_scheduler.sv
// Round-robin job scheduler for a single shared montgomery_reduce: streams the
// owner's T blocks in, walks the k/N constant addresses, routes results back.
module montgomery_reduce_scheduler #(
  parameter int REGISTER_SIZE  = 32,
  parameter int NUM_BLOCKS     = 256,
  parameter int R              = 4096,
  parameter int TIMEOUT_CYCLES = 2**20,
  localparam int CONST_BLOCKS  = R / REGISTER_SIZE,
  localparam int AW            = $clog2(CONST_BLOCKS)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [1:0]               req_in,
  input  logic [REGISTER_SIZE-1:0] t_block0_in,
  input  logic [REGISTER_SIZE-1:0] t_block1_in,
  input  logic [1:0]               t_valid_in,
  output logic [1:0]               grant_out,
  output logic [1:0]               t_ready_out,
  output logic                     mr_valid_out,
  output logic [REGISTER_SIZE-1:0] mr_T_block_out,
  input  logic                     mr_consumed_k_in,
  input  logic                     mr_consumed_N_in,
  output logic [AW-1:0]            k_addr_out,
  output logic [AW-1:0]            n_addr_out,
  input  logic                     mr_valid_in,
  input  logic [REGISTER_SIZE-1:0] mr_data_block_in,
  input  logic                     mr_final_in,
  output logic [1:0]               res_valid_out,
  output logic [REGISTER_SIZE-1:0] res_block_out,
  output logic                     res_final_out,
  output logic                     busy_out,
  output logic                     err_out
);

  localparam int CW = $clog2(NUM_BLOCKS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] blk_cnt;
  logic [CW-1:0] res_cnt;
  logic [TW-1:0] tmo_cnt;

  logic          pick;
  logic          gsel;
  logic          accept;
  logic [CW-1:0] res_cnt_nxt;

  // Contention goes to whoever did not own the reducer last.
  assign pick        = (req_in == 2'b11) ? ~last_grant : req_in[1];
  assign gsel        = grant_out[1];
  assign accept      = (state == LOAD) && t_valid_in[gsel];
  assign res_cnt_nxt = res_cnt + CW'(mr_valid_in);

  assign t_ready_out = (state == LOAD) ? grant_out : 2'b00;
  assign busy_out    = (state != IDLE);

  function automatic logic [AW-1:0] addr_next(input logic [AW-1:0] a);
    return (a == AW'(CONST_BLOCKS - 1)) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      grant_out      <= '0;
      last_grant     <= 1'b1;
      blk_cnt        <= '0;
      res_cnt        <= '0;
      tmo_cnt        <= '0;
      k_addr_out     <= '0;
      n_addr_out     <= '0;
      mr_valid_out   <= 1'b0;
      mr_T_block_out <= '0;
      res_valid_out  <= '0;
      res_block_out  <= '0;
      res_final_out  <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      mr_valid_out  <= 1'b0;
      res_valid_out <= '0;
      res_final_out <= 1'b0;

      // The wrap restarts the N walk at block 0 for every reducer phase.
      if (state != IDLE) begin
        if (mr_consumed_k_in) k_addr_out <= addr_next(k_addr_out);
        if (mr_consumed_N_in) n_addr_out <= addr_next(n_addr_out);
      end

      if (mr_valid_in && state != DRAIN) err_out <= 1'b1;

      case (state)
        IDLE: begin
          if (|req_in) begin
            grant_out  <= pick ? 2'b10 : 2'b01;
            last_grant <= pick;
            blk_cnt    <= '0;
            k_addr_out <= '0;
            n_addr_out <= '0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            mr_T_block_out <= gsel ? t_block1_in : t_block0_in;
            mr_valid_out   <= 1'b1;
            blk_cnt        <= blk_cnt + 1'b1;
            if (blk_cnt == CW'(NUM_BLOCKS - 1)) begin
              state   <= DRAIN;
              tmo_cnt <= '0;
              res_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (mr_valid_in) begin
            res_valid_out <= grant_out;
            res_block_out <= mr_data_block_in;
            res_cnt       <= res_cnt_nxt;
          end
          if (mr_final_in) begin
            res_final_out <= 1'b1;
            state         <= DONE;
            if (res_cnt_nxt != CW'(NUM_BLOCKS / 2)) err_out <= 1'b1;
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Reducer never finished: release the owner without a final.
            err_out <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          grant_out <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
